// File: rtl/otp_macro_initiator.sv
// Command initiator for the OTP macro ready/valid port: issues Init after reset, then one host request at a time.
// Optional per-state handshake timeout is compiled in with `define CALIPTRA_OTP_INITIATOR_TIMEOUT_EN.
`timescale 1ns/1ps

package prim_generic_otp_pkg;
  typedef enum logic [6:0] {
    Read     = 7'b1000101,
    Write    = 7'b0110111,
    ReadRaw  = 7'b1111001,
    WriteRaw = 7'b1100010,
    Zeroize  = 7'b0101100,
    Init     = 7'b0111110
  } cmd_e;

  typedef enum logic [2:0] {
    NoError              = 3'h0,
    MacroError           = 3'h1,
    MacroEccCorrError    = 3'h2,
    MacroEccUncorrError  = 3'h3,
    MacroWriteBlankError = 3'h4
  } err_e;
endpackage

module otp_macro_initiator
  import prim_generic_otp_pkg::*;
#(
  parameter int Width         = 16,
  parameter int Depth         = 1024,
  parameter int SizeWidth     = 2,
  parameter int TimeoutCycles = 1024,
  localparam int AddrWidth    = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int IfWidth      = (2**SizeWidth) * Width
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  cmd_e                 req_cmd_i,
  input  logic [SizeWidth-1:0] req_size_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [IfWidth-1:0]   req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IfWidth-1:0]   rsp_rdata_o,
  output err_e                 rsp_err_o,
  output logic                 rsp_timeout_o,
  output logic                 init_done_o,
  output logic                 fatal_o,
  input  logic                 otp_ready_i,
  output logic                 otp_valid_o,
  output logic [SizeWidth-1:0] otp_size_o,
  output cmd_e                 otp_cmd_o,
  output logic [AddrWidth-1:0] otp_addr_o,
  output logic [IfWidth-1:0]   otp_wdata_o,
  input  logic                 otp_valid_i,
  input  logic [IfWidth-1:0]   otp_rdata_i,
  input  err_e                 otp_err_i
);

  localparam int NumWords = 2**SizeWidth;

  // Codewords of a distance-4 code, so no single or double upset lands on another legal state.
  localparam logic [7:0] ResetSt    = 8'b0101_0101;
  localparam logic [7:0] InitReqSt  = 8'b0011_0011;
  localparam logic [7:0] InitWaitSt = 8'b0000_1111;
  localparam logic [7:0] IdleSt     = 8'b0110_0110;
  localparam logic [7:0] IssueSt    = 8'b0011_1100;
  localparam logic [7:0] WaitSt     = 8'b0101_1010;
  localparam logic [7:0] RespSt     = 8'b0110_1001;
  localparam logic [7:0] ErrorSt    = 8'b1001_0110;

  logic [7:0]           state_q, state_d;
  cmd_e                 cmd_q;
  logic [SizeWidth-1:0] size_q;
  logic [AddrWidth-1:0] addr_q;
  logic [IfWidth-1:0]   wdata_q;
  err_e                 rsp_err_q;
  logic [IfWidth-1:0]   rsp_rdata_q, rdata_masked;
  logic                 init_done_q, fatal_q;
  logic                 init_ok, tmo_rsp, tmo_expired;
  logic                 req_hs, req_legal, cmd_legal, rsp_capture, init_phase;
  logic [AddrWidth:0]   req_end;

  assign req_end   = {1'b0, req_addr_i} + (AddrWidth+1)'(req_size_i);
  assign req_legal = cmd_legal && (req_end < (AddrWidth+1)'(Depth));
  assign req_hs    = (state_q == IdleSt) && req_valid_i;
  assign rsp_capture = (state_q == WaitSt) && otp_valid_i;

  always_comb begin
    case (req_cmd_i)
      Read, Write, ReadRaw, WriteRaw, Zeroize: cmd_legal = 1'b1;
      default:                                 cmd_legal = 1'b0;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NumWords; k++) begin
      rdata_masked[k*Width +: Width] = (k <= int'(size_q)) ? otp_rdata_i[k*Width +: Width] : '0;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    otp_valid_o = 1'b0;
    rsp_valid_o = 1'b0;
    init_ok     = 1'b0;
    tmo_rsp     = 1'b0;
    case (state_q)
      ResetSt: state_d = InitReqSt;
      InitReqSt: begin
        otp_valid_o = 1'b1;
        if (otp_ready_i)      state_d = InitWaitSt;
        else if (tmo_expired) state_d = ErrorSt;
      end
      InitWaitSt: begin
        if (otp_valid_i) begin
          if (otp_err_i != NoError) begin
            state_d = ErrorSt;
          end else begin
            init_ok = 1'b1;
            state_d = IdleSt;
          end
        end else if (tmo_expired) begin
          state_d = ErrorSt;
        end
      end
      IdleSt: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = req_legal ? IssueSt : RespSt;
      end
      IssueSt: begin
        otp_valid_o = 1'b1;
        if (otp_ready_i) begin
          state_d = WaitSt;
        end else if (tmo_expired) begin
          tmo_rsp = 1'b1;
          state_d = RespSt;
        end
      end
      WaitSt: begin
        if (otp_valid_i) begin
          state_d = RespSt;
        end else if (tmo_expired) begin
          tmo_rsp = 1'b1;
          state_d = RespSt;
        end
      end
      RespSt: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IdleSt;
      end
      ErrorSt: state_d = ErrorSt;
      default: state_d = ErrorSt;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ResetSt;
      cmd_q       <= Read;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_err_q   <= NoError;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
      fatal_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        cmd_q   <= req_cmd_i;
        size_q  <= req_size_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        if (!req_legal) begin
          rsp_err_q   <= MacroError;
          rsp_rdata_q <= '0;
        end
      end
      if (rsp_capture) begin
        rsp_err_q   <= otp_err_i;
        rsp_rdata_q <= rdata_masked;
      end
      if (tmo_rsp) begin
        rsp_err_q   <= MacroError;
        rsp_rdata_q <= '0;
      end
      if (init_ok)              init_done_q <= 1'b1;
      if (state_d == ErrorSt)   fatal_q     <= 1'b1;
    end
  end

`ifdef CALIPTRA_OTP_INITIATOR_TIMEOUT_EN
  localparam int CntWidth = $clog2(TimeoutCycles + 1);

  logic [CntWidth-1:0] cnt_q, cnt_inc;
  logic                counting, rsp_timeout_q;

  assign counting    = (state_q == InitReqSt) || (state_q == InitWaitSt) ||
                       (state_q == IssueSt)   || (state_q == WaitSt);
  assign cnt_inc     = cnt_q + CntWidth'(1);
  // Expiry fires in the cycle the count would reach TimeoutCycles, bounding each state to that many cycles.
  assign tmo_expired = counting && (cnt_inc == CntWidth'(TimeoutCycles));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q <= (!counting || (state_d != state_q)) ? '0 : cnt_inc;
      if (tmo_rsp)                         rsp_timeout_q <= 1'b1;
      else if (req_hs || rsp_capture)      rsp_timeout_q <= 1'b0;
    end
  end

  assign rsp_timeout_o = rsp_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles != 0);
  assign tmo_expired        = 1'b0;
  assign rsp_timeout_o      = 1'b0;
`endif

  assign init_phase  = (state_q == InitReqSt);
  assign otp_cmd_o   = init_phase ? Init : cmd_q;
  assign otp_size_o  = init_phase ? '0 : size_q;
  assign otp_addr_o  = init_phase ? '0 : addr_q;
  assign otp_wdata_o = init_phase ? '0 : wdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign init_done_o = init_done_q;
  assign fatal_o     = fatal_q;

endmodule

// File: tb/tb_otp_macro_initiator.sv
// Bench for otp_macro_initiator: behavioural OTP macro, table-driven host requests, hand-written corner sequences.
`timescale 1ns/1ps

module tb_otp_macro_initiator;
  import prim_generic_otp_pkg::*;

`ifdef CALIPTRA_OTP_INITIATOR_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_timeout;
  cmd_e        req_cmd, otp_cmd;
  logic [1:0]  req_size, otp_size;
  logic [9:0]  req_addr, otp_addr;
  logic [63:0] req_wdata, rsp_rdata, otp_wdata, otp_rdata;
  err_e        rsp_err, otp_err;
  logic        init_done, fatal, otp_ready, otp_valid, otp_rsp_valid;

  otp_macro_initiator #(.TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cmd_i(req_cmd),
    .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .init_done_o(init_done), .fatal_o(fatal),
    .otp_ready_i(otp_ready), .otp_valid_o(otp_valid), .otp_size_o(otp_size),
    .otp_cmd_o(otp_cmd), .otp_addr_o(otp_addr), .otp_wdata_o(otp_wdata),
    .otp_valid_i(otp_rsp_valid), .otp_rdata_i(otp_rdata), .otp_err_i(otp_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int otp_valid_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (otp_valid) otp_valid_cycles <= otp_valid_cycles + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural macro: ready after ready_delay cycles, 1-cycle response pulse one cycle later.
  bit          macro_en = 1'b0;
  bit          resp_en = 1'b1;
  int          ready_delay = 0;
  int          hs_count = 0;
  int          init_seen = 0;
  int          hs_cyc = 0;
  cmd_e        cap_cmd;
  logic [1:0]  cap_size;
  logic [9:0]  cap_addr;
  logic [63:0] cap_wdata;
  logic [15:0] mem [1024];

  initial begin : macro_model
    int a;
    logic [15:0] wd;
    otp_ready = 1'b0;
    otp_rsp_valid = 1'b0;
    otp_rdata = '0;
    otp_err = NoError;
    forever begin
      @(posedge clk); #1;
      if (macro_en && otp_valid && !rst) begin
        repeat (ready_delay) begin @(posedge clk); #1; end
        otp_ready = 1'b1;
        cap_cmd = otp_cmd; cap_size = otp_size; cap_addr = otp_addr; cap_wdata = otp_wdata;
        hs_count++;
        if (cap_cmd == Init) init_seen++;
        @(posedge clk); #1;
        otp_ready = 1'b0;
        hs_cyc = cyc;
        if (resp_en) begin
          otp_rdata = {4{16'hDEAD}};
          otp_err = NoError;
          for (int k = 0; k < 4; k++) begin
            if (k <= int'(cap_size)) begin
              a = int'(cap_addr) + k;
              wd = cap_wdata[k*16 +: 16];
              otp_rdata[k*16 +: 16] = 16'h0;
              if (cap_cmd == Read || cap_cmd == ReadRaw) otp_rdata[k*16 +: 16] = mem[a];
              else if (cap_cmd == Write || cap_cmd == WriteRaw) begin
                if ((mem[a] & ~wd) != 16'h0) otp_err = MacroWriteBlankError;
                else mem[a] = mem[a] | wd;
              end
            end
          end
          otp_rsp_valid = 1'b1;
          @(posedge clk); #1;
          otp_rsp_valid = 1'b0;
        end
      end
    end
  end

  task automatic send_req(input cmd_e c, input logic [1:0] s, input logic [9:0] a, input logic [63:0] wd);
    int n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("req_ready before send", req_ready, 1'b1);
    req_valid = 1'b1; req_cmd = c; req_size = s; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output err_e e, output logic [63:0] d, output logic t);
    int n = 0;
    while (!rsp_valid && n < 2*TO + 100) begin @(posedge clk); #1; n++; end
    check("rsp_valid wait", rsp_valid, 1'b1);
    e = rsp_err; d = rsp_rdata; t = rsp_timeout;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("req_ready after rsp accept", req_ready, 1'b1);
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 50) begin @(posedge clk); #1; n++; end
    check("init_done", init_done, 1'b1);
    check("req_ready after init", req_ready, 1'b1);
  endtask

  typedef struct {
    string       name;
    cmd_e        cmd;
    logic [1:0]  size;
    logic [9:0]  addr;
    logic [63:0] wdata;
    err_e        exp_err;
    logic [63:0] exp_rdata;
    bit          exp_issue;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    err_e        e;
    logic [63:0] d;
    logic        t;
    int          vb, hb, n;

    vecs[0]  = '{"read4",       Read,          2'd3, 10'h010,  64'h0,  NoError,              64'h4444_3333_2222_1111, 1'b1};
    vecs[1]  = '{"write_a5",    Write,         2'd0, 10'h020,  64'hA5, NoError,              64'h0,                   1'b1};
    vecs[2]  = '{"readraw_a5",  ReadRaw,       2'd0, 10'h020,  64'h0,  NoError,              64'h0000_0000_0000_00A5, 1'b1};
    vecs[3]  = '{"rewrite_5a",  Write,         2'd0, 10'h020,  64'h5A, MacroWriteBlankError, 64'h0,                   1'b1};
    vecs[4]  = '{"bound_1022",  Read,          2'd1, 10'd1022, 64'h0,  NoError,              64'h0,                   1'b1};
    vecs[5]  = '{"bound_1023",  Read,          2'd1, 10'd1023, 64'h0,  MacroError,           64'h0,                   1'b0};
    vecs[6]  = '{"host_init",   Init,          2'd0, 10'h000,  64'h0,  MacroError,           64'h0,                   1'b0};
    vecs[7]  = '{"bad_cmd",     cmd_e'(7'h00), 2'd0, 10'h000,  64'h0,  MacroError,           64'h0,                   1'b0};
    vecs[8]  = '{"last_word",   Read,          2'd0, 10'd1023, 64'h0,  NoError,              64'h0,                   1'b1};
    vecs[9]  = '{"zeroize",     Zeroize,       2'd1, 10'h030,  64'h0,  NoError,              64'h0,                   1'b1};
    vecs[10] = '{"read2_mid",   Read,          2'd1, 10'h011,  64'h0,  NoError,              64'h0000_0000_3333_2222, 1'b1};

    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    mem[16] = 16'h1111; mem[17] = 16'h2222; mem[18] = 16'h3333; mem[19] = 16'h4444;

    rst = 1'b1; req_valid = 1'b0; req_cmd = Read; req_size = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset otp_valid", otp_valid, 1'b0);
    check("reset req_ready", req_ready, 1'b0);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_err", 64'(rsp_err), 64'(NoError));
    check("reset rsp_rdata", rsp_rdata, 64'h0);
    check("reset otp_cmd", 64'(otp_cmd), 64'(Read));
    check("reset init_done", init_done, 1'b0);
    check("reset fatal", fatal, 1'b0);
    check("reset rsp_timeout", rsp_timeout, 1'b0);

    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ResetSt otp_valid", otp_valid, 1'b0);
    @(negedge clk);
    check("init otp_valid", otp_valid, 1'b1);
    check("init otp_cmd", 64'(otp_cmd), 64'(Init));
    check("init payload", {otp_size, otp_addr, otp_wdata}, 76'h0);
    macro_en = 1'b1;
    wait_init();
    check("init issued once", init_seen, 1);
    check("no fatal after init", fatal, 1'b0);

    for (int i = 0; i < NV; i++) begin
      vb = otp_valid_cycles;
      hb = hs_count;
      send_req(vecs[i].cmd, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].exp_issue) check({vecs[i].name, " otp_valid next cycle"}, otp_valid, 1'b1);
      else                   check({vecs[i].name, " rsp_valid next cycle"}, rsp_valid, 1'b1);
      get_rsp(e, d, t);
      check({vecs[i].name, " err"}, 64'(e), 64'(vecs[i].exp_err));
      check({vecs[i].name, " rdata"}, d, vecs[i].exp_rdata);
      check({vecs[i].name, " timeout"}, t, 1'b0);
      check({vecs[i].name, " issued"}, hs_count - hb, int'(vecs[i].exp_issue));
      if (vecs[i].exp_issue) check({vecs[i].name, " macro addr/size"}, {cap_addr, cap_size}, {vecs[i].addr, vecs[i].size});
      else                   check({vecs[i].name, " otp_valid never"}, otp_valid_cycles - vb, 0);
    end

    // Host holds off the response for 5 cycles.
    send_req(Read, 2'd3, 10'h010, 64'h0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp rsp_valid held", rsp_valid, 1'b1);
      check("bp rdata stable", rsp_rdata, 64'h4444_3333_2222_1111);
      check("bp req_ready low", req_ready, 1'b0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    check("bp req_ready after accept", req_ready, 1'b1);

    // Macro holds off ready for 3 cycles.
    ready_delay = 3;
    send_req(Read, 2'd1, 10'h012, 64'h0);
    check("ready bp otp_valid rises", otp_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ready bp otp_valid held", otp_valid, 1'b1);
      check("ready bp payload stable", {otp_cmd, otp_size, otp_addr}, {Read, 2'd1, 10'h012});
    end
    get_rsp(e, d, t);
    check("ready bp rdata", d, 64'h0000_0000_4444_3333);
    ready_delay = 0;

    // Reset while the request is stuck in IssueSt.
    macro_en = 1'b0;
    send_req(Read, 2'd0, 10'h010, 64'h0);
    @(negedge clk);
    check("stuck otp_valid", otp_valid, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midop reset otp_valid", otp_valid, 1'b0);
    check("midop reset init_done", init_done, 1'b0);
    check("midop reset otp_cmd", 64'(otp_cmd), 64'(Read));
    check("midop reset req_ready", req_ready, 1'b0);
    macro_en = 1'b1;
    wait_init();
    check("init reissued", init_seen, 2);

`ifdef CALIPTRA_OTP_INITIATOR_TIMEOUT_EN
    resp_en = 1'b0;
    send_req(Read, 2'd0, 10'h010, 64'h0);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("timeout wait cycles", cyc - hs_cyc, TO);
    get_rsp(e, d, t);
    check("timeout err", 64'(e), 64'(MacroError));
    check("timeout flag", t, 1'b1);
    resp_en = 1'b1;

    macro_en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    while (!fatal && n < 50) begin @(negedge clk); n++; end
    check("init timeout fatal", fatal, 1'b1);
    check("init timeout init_done", init_done, 1'b0);
    @(negedge clk);
    check("error req_ready", req_ready, 1'b0);
    check("error otp_valid", otp_valid, 1'b0);
    macro_en = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wait_init();
    check("fatal cleared by reset", fatal, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otp_macro_initiator.md
# otp_macro_initiator

Command initiator for the OTP macro ready/valid interface (cmd/size/addr/wdata request, valid/rdata/err response). Sits between an FPGA host-side register/AXI bridge and the backdoor OTP macro emulator. After reset it issues the mandatory Init command, then forwards single host requests one at a time. It returns read data, the macro error code and a timeout indication to the host.

## Interface
- `Width`, 16, native OTP word width in bits.
- `Depth`, 1024, OTP depth in native words.
- `SizeWidth`, 2, size field width; one transfer carries up to 2**SizeWidth words.
- `TimeoutCycles`, 1024, maximum cycles to wait for a macro handshake or response.
- Derived: `AddrWidth` = vbits(Depth); `IfWidth` = 2**SizeWidth*Width.

- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: host request valid.
- `req_ready_o` out 1: host request ready.
- `req_cmd_i` in cmd_e: host command (prim_generic_otp_pkg).
- `req_size_i` in SizeWidth: number of words minus 1.
- `req_addr_i` in AddrWidth: start word address.
- `req_wdata_i` in IfWidth: write data, word k at bits [k*Width +: Width].
- `rsp_valid_o` out 1: response valid, held until accepted.
- `rsp_ready_i` in 1: host response ready.
- `rsp_rdata_o` out IfWidth: read data; words above size are zero.
- `rsp_err_o` out err_e: macro or initiator error code.
- `rsp_timeout_o` out 1: response was produced by timeout.
- `init_done_o` out 1: Init completed; sticky until reset.
- `fatal_o` out 1: Init failed; sticky until reset.
- `otp_ready_i` in 1: macro ready.
- `otp_valid_o` out 1: macro command valid.
- `otp_size_o` out SizeWidth: macro size.
- `otp_cmd_o` out cmd_e: macro command.
- `otp_addr_o` out AddrWidth: macro address.
- `otp_wdata_o` out IfWidth: macro write data.
- `otp_valid_i` in 1: macro response valid (1-cycle pulse).
- `otp_rdata_i` in IfWidth: macro read data.
- `otp_err_i` in err_e: macro error.

## Operation
- FSM states: ResetSt, InitReqSt, InitWaitSt, IdleSt, IssueSt, WaitSt, RespSt, ErrorSt.
- Sparse encoding with minimum Hamming distance 4. Any illegal state moves to ErrorSt and asserts `fatal_o`.
- ResetSt moves to InitReqSt unconditionally on the first cycle after reset.
- InitReqSt:
  - Drive `otp_valid_o`=1 and `otp_cmd_o`=Init; size, addr and wdata are 0.
  - On `otp_ready_i`, go to InitWaitSt.
- InitWaitSt:
  - On `otp_valid_i`, set `init_done_o`=1 and go to IdleSt.
  - If `otp_err_i`≠NoError, set `fatal_o` and go to ErrorSt instead.
- IdleSt: `req_ready_o`=1. On handshake, register cmd, size, addr and wdata, then check the request:
  - cmd=Init, or cmd not in {Read, Write, ReadRaw, WriteRaw, Zeroize}: go to RespSt with `rsp_err_o`=MacroError. Nothing is issued.
  - addr+size ≥ Depth, evaluated at AddrWidth+1 bits: same rejection, MacroError, no issue.
  - Otherwise go to IssueSt.
- IssueSt: hold `otp_valid_o`=1 with the registered payload until `otp_ready_i`, then go to WaitSt.
- WaitSt:
  - On `otp_valid_i`, capture `otp_err_i` and `otp_rdata_i`.
  - Words with index > size are masked to 0.
  - Go to RespSt.
- RespSt: hold `rsp_valid_o`=1 with stable data until `rsp_ready_i`, then go to IdleSt.
- ErrorSt: terminal. `req_ready_o`=0 and `otp_valid_o`=0; only reset leaves it.
- An `otp_valid_i` pulse outside WaitSt and InitWaitSt is ignored.

## Timing
- Reset values:
  - All outputs are 0; `rsp_err_o`=NoError.
  - `otp_cmd_o`=Read, but it is qualified by `otp_valid_o`=0.
  - State is ResetSt.
- Host request accepted in cycle N: `otp_valid_o` rises in N+1. The `otp_*` payload comes directly from registers.
- Macro response pulse in cycle M: `rsp_valid_o` rises in M+1.
- After `rsp_ready_i` in cycle R, `req_ready_o` rises in R+1. There is no back-to-back acceptance.
- Rejected request accepted in cycle N: `rsp_valid_o` rises in N+1.
- Reset asserted mid-operation: the next cycle is ResetSt, all outputs return to reset values, and Init is reissued.

## Configuration
- Macro `CALIPTRA_OTP_INITIATOR_TIMEOUT_EN`.
- Defined: a counter runs in InitReqSt, InitWaitSt, IssueSt and WaitSt.
  - Width is vbits(TimeoutCycles+1); it clears on every state change.
  - When the counter reaches TimeoutCycles in IssueSt or WaitSt: drop `otp_valid_o`, go to RespSt, set `rsp_err_o`=MacroError and `rsp_timeout_o`=1.
  - When it reaches TimeoutCycles in InitReqSt or InitWaitSt: set `fatal_o` and go to ErrorSt.
- Undefined: no counter; the FSM waits indefinitely and `rsp_timeout_o` is tied to 0.

## Test plan
- **Init:** after reset release, macro responds ready in 1 cycle and valid 1 cycle later → `otp_cmd_o`=Init observed once, `init_done_o`=1, `req_ready_o`=1.
- **Read:** Read with addr=0x10, size=3, RAM words 0x1111..0x4444 → `otp_valid_o` carries addr 0x10 and size 3; `rsp_rdata_o`=0x4444_3333_2222_1111; `rsp_err_o`=NoError.
- **Write then read:** Write with addr=0x20, size=0, wdata=0x00A5 → NoError. A ReadRaw of the same word returns 0x00A5 in word 0 with upper words 0. A second write of 0x005A returns MacroWriteBlankError.
- **Bounds:**
  - addr=1022, size=1 → accepted (1023 < 1024).
  - addr=1023, size=1 → MacroError, `otp_valid_o` never asserted.
  - cmd=Init from the host → MacroError.
- **Backpressure:** `rsp_ready_i` held low for 5 cycles → `rsp_valid_o` and the data are stable for 5 cycles and `req_ready_o` stays 0. The macro holds `otp_ready_i` low for 3 cycles → `otp_valid_o` and the payload are stable.
- **Timeout (macro defined, TimeoutCycles=8):**
  - Macro never returns `otp_valid_i` → response after 8 WaitSt cycles with `rsp_timeout_o`=1 and MacroError.
  - Macro never ready during Init → `fatal_o`=1; reset mid-wait recovers to Init.
